// File: rtl/prog_lut_if.sv
// Handshake bundle for prog_lut_eval: table-load port, input vector stream and result stream.
// hit_cnt exists only when LUT_HITCNT_EN is defined.
interface prog_lut_if #(
  parameter int N = 4
);
  logic         cfg_start;
  logic         cfg_bit;
  logic         cfg_bit_vld;
  logic         cfg_busy;
  logic         cfg_done;
  logic         in_vld;
  logic         in_rdy;
  logic [N-1:0] in_vec;
  logic         out_vld;
  logic         out_rdy;
  logic         out_s;
  logic [N-1:0] out_vec;
`ifdef LUT_HITCNT_EN
  logic [15:0]  hit_cnt;

  modport slave (
    input  cfg_start, cfg_bit, cfg_bit_vld, in_vld, in_vec, out_rdy,
    output cfg_busy, cfg_done, in_rdy, out_vld, out_s, out_vec, hit_cnt
  );
  modport master (
    output cfg_start, cfg_bit, cfg_bit_vld, in_vld, in_vec, out_rdy,
    input  cfg_busy, cfg_done, in_rdy, out_vld, out_s, out_vec, hit_cnt
  );
`else
  modport slave (
    input  cfg_start, cfg_bit, cfg_bit_vld, in_vld, in_vec, out_rdy,
    output cfg_busy, cfg_done, in_rdy, out_vld, out_s, out_vec
  );
  modport master (
    output cfg_start, cfg_bit, cfg_bit_vld, in_vld, in_vec, out_rdy,
    input  cfg_busy, cfg_done, in_rdy, out_vld, out_s, out_vec
  );
`endif
endinterface

// File: rtl/prog_lut_eval.sv
// Registered N-input LUT with a serially reloadable truth table and valid/ready streams.
// Optional saturating hit counter on result transfers with out_s=1: define LUT_HITCNT_EN.
module prog_lut_eval #(
  parameter int                N          = 4,
  parameter logic [2**N-1:0]   DEFAULT_TT = 16'hA500
) (
  input  logic      clk,
  input  logic      rst_n,
  prog_lut_if.slave bus
);
  localparam int TW = 2**N;

  typedef enum logic {RUN, LOAD} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tt_q, shadow_q;
  logic [N-1:0]    cnt_q;
  logic            cfg_done_q;
  logic            out_vld_q, out_s_q;
  logic [N-1:0]    out_vec_q;
  logic            in_rdy;
  logic            accept, drain, bit_take, last_bit;

  always_comb begin
    in_rdy   = (state_q == RUN) && (!out_vld_q || bus.out_rdy);
    accept   = bus.in_vld && in_rdy;
    drain    = out_vld_q && bus.out_rdy;
    bit_take = (state_q == LOAD) && bus.cfg_bit_vld;
    last_bit = bit_take && (cnt_q == '1);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // next-state logic; LOAD can only be left by completing the table
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (bus.cfg_start) state_d = LOAD;
      LOAD:    if (last_bit)      state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // outputs
  always_comb begin
    bus.cfg_busy = (state_q == LOAD);
    bus.cfg_done = cfg_done_q;
    bus.in_rdy   = in_rdy;
    bus.out_vld  = out_vld_q;
    bus.out_s    = out_s_q;
    bus.out_vec  = out_vec_q;
  end

  // table load path: shadow shifts MSB first, table swaps on the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_q       <= DEFAULT_TT;
      shadow_q   <= '0;
      cnt_q      <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      cfg_done_q <= last_bit;
      if (state_q == RUN && bus.cfg_start) cnt_q <= '0;
      if (bit_take) begin
        shadow_q <= {shadow_q[TW-2:0], bus.cfg_bit};
        cnt_q    <= cnt_q + 1'b1;
      end
      if (last_bit) tt_q <= {shadow_q[TW-2:0], bus.cfg_bit};
    end
  end

  // result register: load on accept, clear valid on a drain with no refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_s_q   <= 1'b0;
      out_vec_q <= '0;
    end else if (accept) begin
      out_vld_q <= 1'b1;
      out_s_q   <= tt_q[bus.in_vec];
      out_vec_q <= bus.in_vec;
    end else if (drain) begin
      out_vld_q <= 1'b0;
    end
  end

`ifdef LUT_HITCNT_EN
  logic [15:0] hit_q;

  // table swap clears the counter and beats a coincident hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                hit_q <= '0;
    else if (last_bit)                         hit_q <= '0;
    else if (drain && out_s_q && hit_q != '1)  hit_q <= hit_q + 16'd1;
  end

  assign bus.hit_cnt = hit_q;
`endif
endmodule

// File: tb/tb_prog_lut_eval.sv
// Randomised directed bench for prog_lut_eval against a transaction-level table model.
// Also exercises an N=3 parity instance; hit counter checks compile only with LUT_HITCNT_EN.
module tb_prog_lut_eval;
  localparam int          N   = 4;
  localparam int          TW  = 16;
  localparam logic [15:0] DTT = 16'hA500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_lut_if #(.N(4)) b4 ();
  prog_lut_if #(.N(3)) b3 ();

  prog_lut_eval #(.N(4), .DEFAULT_TT(16'hA500)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  prog_lut_eval #(.N(3), .DEFAULT_TT(8'h96))    dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  int n_checks = 0;
  int n_fail   = 0;

  // reference state: table as a bit vector, one pending result, loaded bits as a queue
  logic [15:0] m_tt;
  bit          m_load, m_ov, m_os, m_done;
  logic [3:0]  m_ovec;
  bit          m_q[$];
  int          m_hit;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_tt = DTT; m_load = 0; m_ov = 0; m_os = 0; m_ovec = '0; m_done = 0; m_hit = 0;
    m_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_out_vld", b4.out_vld, 1'b0);
    chk("rst_out_s", b4.out_s, 1'b0);
    chk("rst_out_vec", b4.out_vec, 4'h0);
    chk("rst_cfg_busy", b4.cfg_busy, 1'b0);
    chk("rst_cfg_done", b4.cfg_done, 1'b0);
    chk("rst_in_rdy", b4.in_rdy, 1'b1);
`ifdef LUT_HITCNT_EN
    chk("rst_hit_cnt", b4.hit_cnt, 16'h0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // one clock of stimulus; called at posedge+1, returns at posedge+1
  task automatic step(input bit iv, input logic [3:0] vec, input bit ordy,
                      input bit cs, input bit bv, input bit b);
    bit exp_rdy, drain, acc, fin, os_old;
    b4.in_vld = iv; b4.in_vec = vec; b4.out_rdy = ordy;
    b4.cfg_start = cs; b4.cfg_bit_vld = bv; b4.cfg_bit = b;
    #1;
    exp_rdy = !m_load && (!m_ov || ordy);
    chk("in_rdy", b4.in_rdy, exp_rdy);
    drain  = m_ov && ordy;
    acc    = iv && exp_rdy;
    os_old = m_ov && m_os;
    fin    = m_load && bv && (m_q.size() == TW - 1);
    if (acc) begin
      m_ov = 1; m_os = m_tt[vec]; m_ovec = vec;
    end else if (drain) m_ov = 0;
    if (fin) m_hit = 0;
    else if (drain && os_old && m_hit < 65535) m_hit++;
    if (!m_load) begin
      if (cs) begin m_load = 1; m_q.delete(); end
    end else if (bv) begin
      m_q.push_back(b);
      if (m_q.size() == TW) begin
        for (int i = 0; i < TW; i++) m_tt[TW-1-i] = m_q[i];
        m_load = 0;
      end
    end
    m_done = fin;
    @(posedge clk); #1;
    chk("out_vld", b4.out_vld, m_ov);
    if (m_ov) begin
      chk("out_s", b4.out_s, m_os);
      chk("out_vec", b4.out_vec, m_ovec);
    end
    chk("cfg_busy", b4.cfg_busy, m_load);
    chk("cfg_done", b4.cfg_done, m_done);
`ifdef LUT_HITCNT_EN
    chk("hit_cnt", b4.hit_cnt, m_hit[15:0]);
`endif
  endtask

  task automatic rand_step(input bit cs, input bit bv, input bit b);
    step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 3) != 0), cs, bv, b);
  endtask

  // fixed_gaps: idle cycle before bits 2, 7, 12; otherwise random gaps with spurious cfg_start
  task automatic load_table(input logic [15:0] t, input bit fixed_gaps);
    rand_step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < TW; i++) begin
      if (fixed_gaps) begin
        if (i % 5 == 2) rand_step(1'b0, 1'b0, 1'b0);
      end else begin
        for (int g = $urandom_range(0, 2); g > 0; g--)
          rand_step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom));
      end
      rand_step(1'($urandom_range(0, 1)), 1'b1, t[15-i]);
    end
  endtask

  initial begin
    b4.in_vld = 0; b4.in_vec = '0; b4.out_rdy = 1;
    b4.cfg_start = 0; b4.cfg_bit_vld = 0; b4.cfg_bit = 0;
    b3.in_vld = 0; b3.in_vec = '0; b3.out_rdy = 1;
    b3.cfg_start = 0; b3.cfg_bit_vld = 0; b3.cfg_bit = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // default table sweep with spot checks of the reset function
    for (int v = 0; v < 16; v++) begin
      step(1'b1, 4'(v), 1'b1, 1'b0, 1'b0, 1'b0);
      if (v == 10) chk("dflt_A", b4.out_s, 1'b1);
      if (v == 9)  chk("dflt_9", b4.out_s, 1'b0);
    end
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    // backpressure: result for 8 held while consumer stalls
    step(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold_s", b4.out_s, 1'b1);
      chk("hold_vec", b4.out_vec, 4'h8);
    end
    step(1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) rand_step(1'b0, 1'b0, 1'b0);

    // reload 8001 with gaps, then probe corners and middle
    load_table(16'h8001, 1'b1);
    step(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tt8001_0", b4.out_s, 1'b1);
    step(1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tt8001_F", b4.out_s, 1'b1);
    step(1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("tt8001_8", b4.out_s, 1'b0);

    for (int k = 0; k < 4; k++) begin
      load_table(16'($urandom), 1'b0);
      for (int i = 0; i < 40; i++) rand_step(1'b0, 1'b0, 1'b0);
    end

    // reset after 7 of 16 bits restores the default table
    step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'($urandom));
    do_reset();
    for (int v = 0; v < 16; v++) step(1'b1, 4'(v), 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef LUT_HITCNT_EN
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("hit_ten", b4.hit_cnt, 16'd10);
    load_table(16'hFFFF, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("hit_clr", b4.hit_cnt, 16'd0);
    force dut4.hit_q = 16'hFFFF;
    #1;
    release dut4.hit_q;
    m_hit = 65535;
    step(1'b1, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("hit_sat", b4.hit_cnt, 16'hFFFF);
`endif

    // N=3 parity instance, back-to-back at one result per clock
    for (int v = 0; v <= 8; v++) begin
      logic [2:0] pv;
      b3.in_vld = (v < 8);
      b3.in_vec = 3'(v);
      #1;
      chk("p3_in_rdy", b3.in_rdy, 1'b1);
      @(posedge clk); #1;
      if (v < 8) begin
        pv = 3'(v);
        chk("p3_out_vld", b3.out_vld, 1'b1);
        chk("p3_out_s", b3.out_s, pv[0] ^ pv[1] ^ pv[2]);
        chk("p3_out_vec", b3.out_vec, pv);
      end else begin
        chk("p3_drain", b3.out_vld, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
